// File: rtl/serial_add_seq.sv
// Bit-serial adder: one shared full_adder cell stepped LSB-first, one bit per clock,
// with the carry held in a flop between bits and a start/done handshake.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-1:0] sum_full;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_s, fa_c;
   logic             last_bit;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

   // The result register only needs the WIDTH-1 bits already produced; the final
   // bit comes straight from the adder on the completing edge.
   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_full = fa_s;
      end else begin : g_wn
         logic [WIDTH-2:0] r_sh;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_sh <= '0;
            else if (state == RUN)
               r_sh <= sum_full[WIDTH-1:1];
         end

         assign sum_full = {fa_s, r_sh};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand shifting, carry chaining and the result load on the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         S     <= '0;
         Cout  <= 1'b0;
         V     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  carry <= Cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= fa_c;
               cnt   <= cnt + CW'(1);
               if (last_bit) begin
                  S    <= sum_full;
                  Cout <= fa_c;
                  V    <= carry ^ fa_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
